// File: rtl/tx_client_arb.sv
// tx_client_arb: round-robin arbiter sharing one Ethernet Tx engine between N clients.
// The grant is held from arbitration through the end of the packet and a short drain.
// While granted, ack, warn and data are steered combinationally between the engine and the winner.
// Optional watchdog: define TX_ARB_TIMEOUT_EN to time out grants stuck in REQ.
module tx_client_arb #(
    parameter int unsigned N              = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      cli_req,
    input  logic [11*N-1:0]   cli_len,
    input  logic [8*N-1:0]    cli_data,
    output logic [N-1:0]      cli_ack,
    output logic [N-1:0]      cli_warn,
    output logic              mac_req,
    output logic [10:0]       mac_len,
    input  logic              mac_ack,
    input  logic              mac_warn,
    output logic [7:0]        mac_data,
    output logic [N-1:0]      grant,
    output logic              timeout_err
);

    localparam int unsigned LEN_W  = 11;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = (N > 2) ? $clog2(N) : 1;
    localparam int unsigned WD_W   = 12;

    // Reject client counts and watchdog limits outside the supported range.
    if (N < 2 || N > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 4095) begin : g_cfg_err
        $error("tx_client_arb: unsupported N or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [N-1:0]       r_grant;
    logic [IDX_W-1:0]   r_last;
    logic [LEN_W-1:0]   r_mac_len;
    logic               r_drain_done;

    logic [N-1:0]       w_mask;
    logic [N-1:0]       w_cand;
    logic [N-1:0]       w_win_hot;
    logic [IDX_W-1:0]   w_win_idx;
    logic [IDX_W-1:0]   r_gidx;
    logic [LEN_W-1:0]   w_win_len;
    logic               w_found;
    logic               w_gnt_req;
    logic               w_timeout;

`ifdef TX_ARB_TIMEOUT_EN
    logic [WD_W-1:0]    r_wd_cnt;
    logic [N-1:0]       r_mask;
    logic               r_timeout_err;

    assign w_mask      = r_mask;
    assign w_timeout   = (r_state == ST_REQ) && w_gnt_req &&
                         (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = r_timeout_err;

    // Watchdog: count REQ cycles, flag a timeout and mask the stuck client until it drops req.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt      <= '0;
            r_mask        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wd_cnt <= (r_state == ST_REQ) ? r_wd_cnt + WD_W'(1) : '0;
            r_mask   <= (r_mask & cli_req) | (w_timeout ? r_grant : '0);
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_mask      = '0;
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign w_cand    = cli_req & ~w_mask;
    assign w_gnt_req = |(r_grant & cli_req);
    assign grant     = r_grant;
    assign mac_len   = r_mac_len;

    // Round-robin pick: first eligible client scanning upward from the one after the last winner.
    always_comb begin
        w_found   = 1'b0;
        w_win_hot = '0;
        w_win_idx = '0;
        w_win_len = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (!w_found && w_cand[k] && (((32'(r_last) + off) % N) == k)) begin
                    w_found      = 1'b1;
                    w_win_hot[k] = 1'b1;
                    w_win_idx    = IDX_W'(k);
                    w_win_len    = cli_len[LEN_W*k +: LEN_W];
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state: arbitrate, follow the winner's request, then drain until the engine lets go.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!w_gnt_req || w_timeout) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_drain_done && !mac_ack) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: request follows the winner in REQ; ack/warn/data are steered by the grant.
    always_comb begin
        mac_req  = 1'b0;
        mac_data = '0;
        cli_ack  = r_grant & {N{mac_ack}};
        cli_warn = r_grant & {N{mac_warn}};
        if (r_state == ST_REQ) begin
            mac_req = w_gnt_req;
        end
        for (int unsigned k = 0; k < N; k++) begin
            if (r_grant[k]) begin
                mac_data = cli_data[BYTE_W*k +: BYTE_W];
            end
        end
    end

    // Grant, latched length and round-robin pointer; pointer advances only when a grant retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= '0;
            r_gidx       <= '0;
            r_last       <= IDX_W'(N - 1);
            r_mac_len    <= '0;
            r_drain_done <= 1'b0;
        end else begin
            r_drain_done <= (r_state == ST_DRAIN);
            if (r_state == ST_IDLE && w_next == ST_REQ) begin
                r_grant   <= w_win_hot;
                r_gidx    <= w_win_idx;
                r_mac_len <= w_win_len;
            end else if (r_state == ST_DRAIN && w_next == ST_IDLE) begin
                r_grant <= '0;
                r_last  <= r_gidx;
            end
        end
    end

endmodule

// File: tb/tb_tx_client_arb.sv
// Testbench for tx_client_arb: directed scenarios plus randomized client traffic,
// every cycle compared against a packet-level reference model.
// Timeout scenario compiled only when TX_ARB_TIMEOUT_EN is defined.
module tb_tx_client_arb;
    localparam int unsigned N  = 2;
    localparam int unsigned TO = 16;

    logic            clk;
    logic            rst;
    logic [N-1:0]    cli_req;
    logic [11*N-1:0] cli_len;
    logic [8*N-1:0]  cli_data;
    logic [N-1:0]    cli_ack;
    logic [N-1:0]    cli_warn;
    logic            mac_req;
    logic [10:0]     mac_len;
    logic            mac_ack;
    logic            mac_warn;
    logic [7:0]      mac_data;
    logic [N-1:0]    grant;
    logic            timeout_err;

    int total = 0;
    int bad   = 0;

    // reference model: owner (-1 none), phase 0 idle / 1 sending / 2 draining
    int          m_own, m_phase, m_dcnt, m_wd, m_last;
    logic [10:0] m_len;
    logic [N-1:0] m_mask;
    logic        m_terr;

    // client behaviour
    int c_pkts[N];
    int c_hold[N];
    int c_gap[N];
    int gap_max;
    int fixed_len;

    // observations
    int           d_log[$];
    logic [N-1:0] prev_grant;
    logic         prev_warn;
    int           w0_cnt, w1_cnt, byte_cnt, mreq0_cnt;

    tx_client_arb #(.N(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .cli_req(cli_req), .cli_len(cli_len), .cli_data(cli_data),
        .cli_ack(cli_ack), .cli_warn(cli_warn), .mac_req(mac_req), .mac_len(mac_len),
        .mac_ack(mac_ack), .mac_warn(mac_warn), .mac_data(mac_data), .grant(grant),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_phase = 0; m_dcnt = 0; m_wd = 0; m_last = N - 1;
        m_len = '0; m_mask = '0; m_terr = 1'b0;
        prev_grant = '0; prev_warn = 1'b0;
        for (int k = 0; k < N; k++) begin
            c_pkts[k] = 0; c_hold[k] = 0; c_gap[k] = 0;
        end
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_edge();
        logic [N-1:0] cand;
        logic [N-1:0] nmask;
        cand  = cli_req & ~m_mask;
        nmask = m_mask & cli_req;
        case (m_phase)
            0: begin
                for (int off = 1; off <= int'(N); off++) begin
                    int c;
                    c = (m_last + off) % int'(N);
                    if (m_phase == 0 && cand[c]) begin
                        m_own = c; m_len = cli_len[11*c +: 11]; m_phase = 1; m_wd = 0;
                    end
                end
            end
            1: begin
                if (!cli_req[m_own]) begin
                    m_phase = 2; m_dcnt = 0;
                end
`ifdef TX_ARB_TIMEOUT_EN
                else if (m_wd + 1 == int'(TO)) begin
                    m_phase = 2; m_dcnt = 0; m_terr = 1'b1; nmask[m_own] = 1'b1;
                end
`endif
                else begin
                    m_wd++;
                end
            end
            default: begin
                if (m_dcnt + 1 >= 2 && !mac_ack) begin
                    m_phase = 0; m_last = m_own; m_own = -1;
                end else begin
                    m_dcnt++;
                end
            end
        endcase
        m_mask = nmask;
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg;
        logic [7:0]   ed;
        logic         er;
        int           gi;
        #1;
        eg = '0; ed = 8'h00; er = 1'b0;
        if (m_own >= 0) begin
            eg[m_own] = 1'b1;
            ed = cli_data[8*m_own +: 8];
            er = (m_phase == 1) && cli_req[m_own];
        end
        chk("grant", 32'(grant), 32'(eg));
        chk("mac_req", 32'(mac_req), 32'(er));
        chk("mac_data", 32'(mac_data), 32'(ed));
        chk("cli_ack", 32'(cli_ack), 32'(eg & {N{mac_ack}}));
        chk("cli_warn", 32'(cli_warn), 32'(eg & {N{mac_warn}}));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        if (m_own >= 0) chk("mac_len", 32'(mac_len), 32'(m_len));
        if (cli_warn[0] === 1'b1) w0_cnt++;
        if (cli_warn[1] === 1'b1) w1_cnt++;
        if (prev_warn && grant === 2'b01 && mac_data === cli_data[7:0]) byte_cnt++;
        if (mac_req === 1'b1 && grant === 2'b01) mreq0_cnt++;
        if (grant !== '0 && prev_grant === '0) begin
            gi = -1;
            for (int k = 0; k < N; k++) if (grant[k] === 1'b1) gi = k;
            d_log.push_back(gi);
        end
        prev_grant = grant;
        prev_warn  = mac_warn;
    endtask

    task automatic tick();
        check_outputs();
        model_edge();
        @(negedge clk);
    endtask

    // Each client raises req, holds it a while after being granted, drops it, pauses, repeats.
    task automatic drive_clients();
        for (int k = 0; k < N; k++) begin
            if (cli_req[k]) begin
                if (m_own == k && m_phase == 1) begin
                    if (c_hold[k] == 0) begin
                        cli_req[k] = 1'b0; c_pkts[k]--;
                        c_gap[k] = int'($urandom_range(0, gap_max));
                    end else begin
                        c_hold[k]--;
                    end
                end
            end else if (c_gap[k] > 0) begin
                c_gap[k]--;
            end else if (c_pkts[k] > 0) begin
                cli_req[k] = 1'b1;
                c_hold[k]  = int'($urandom_range(1, 10));
                cli_len[11*k +: 11] = (fixed_len > 0) ? 11'(fixed_len) : 11'($urandom_range(1, 1500));
            end
        end
    endtask

    task automatic auto_cycle();
        drive_clients();
        cli_data = 16'($urandom);
        mac_warn = 1'($urandom_range(0, 1));
        mac_ack  = (m_phase == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
        tick();
    endtask

    function automatic bit busy();
        busy = (cli_req != '0) || (m_phase != 0);
        for (int k = 0; k < N; k++) if (c_pkts[k] > 0) busy = 1'b1;
    endfunction

    task automatic run_quiet(input string tag);
        int n;
        n = 0;
        while (busy() && n < 500) begin
            auto_cycle();
            n++;
        end
        chk({tag, "_bound"}, 32'(busy()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; cli_req = '0; cli_len = '0; cli_data = '0; mac_ack = 1'b0; mac_warn = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_mac_req", 32'(mac_req), 32'd0);
        chk("rst_mac_len", 32'(mac_len), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_mac_data", 32'(mac_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int exp031[4] = '{0, 1, 0, 1};
        gap_max = 0; fixed_len = 0;
        w0_cnt = 0; w1_cnt = 0; byte_cnt = 0; mreq0_cnt = 0;
        do_reset();

        // lone client 0, len 12, 20-cycle request, ack once, 12 warn strobes
        w0_cnt = 0; w1_cnt = 0; byte_cnt = 0;
        cli_len[10:0] = 11'd12;
        cli_req[0] = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i == 20) cli_req[0] = 1'b0;
            mac_ack  = (i == 2);
            mac_warn = (i >= 3 && i < 15);
            cli_data = 16'($urandom);
            if (i == 1) begin
                #1;
                chk("030_grant", 32'(grant), 32'd1);
                chk("030_mac_len", 32'(mac_len), 32'd12);
            end
            tick();
        end
        chk("030_warn0", 32'(w0_cnt), 32'd12);
        chk("030_warn1", 32'(w1_cnt), 32'd0);
        chk("030_bytes", 32'(byte_cnt), 32'd12);

        // reset mid-packet after 5 warn strobes
        do_reset();
        cli_len[10:0] = 11'd100;
        cli_req[0] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            mac_ack  = (i >= 1);
            mac_warn = (i >= 2);
            cli_data = 16'($urandom);
            tick();
        end
        rst = 1'b1;
        #1;
        chk("033_mac_req", 32'(mac_req), 32'd0);
        chk("033_grant", 32'(grant), 32'd0);
        chk("033_cli_ack", 32'(cli_ack), 32'd0);
        chk("033_cli_warn", 32'(cli_warn), 32'd0);
        chk("033_mac_data", 32'(mac_data), 32'd0);
        cli_req = '0; mac_ack = 1'b0; mac_warn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // simultaneous requests, two rounds, len 8
        d_log.delete();
        fixed_len = 8; gap_max = 0;
        c_pkts[0] = 1; c_pkts[1] = 1;
        run_quiet("031_r1");
        c_pkts[0] = 1; c_pkts[1] = 1;
        run_quiet("031_r2");
        chk("031_count", 32'(d_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) if (i < d_log.size()) chk("031_order", 32'(d_log[i]), 32'(exp031[i]));

        // length change mid-grant must not move mac_len
        cli_len[10:0] = 11'd12;
        cli_req[0] = 1'b1;
        mac_ack = 1'b0; mac_warn = 1'b0;
        tick();
        tick();
        cli_len[10:0] = 11'd40;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("035_mac_len", 32'(mac_len), 32'd12);
            tick();
        end
        cli_req[0] = 1'b0;
        repeat (4) tick();

        // client 1 keeps requesting, client 0 requests three packets: strict alternation
        d_log.delete();
        fixed_len = 0; gap_max = 0;
        c_pkts[1] = 100;
        auto_cycle();
        c_pkts[0] = 3;
        begin
            int n;
            n = 0;
            while (c_pkts[0] > 0 && n < 500) begin
                auto_cycle();
                n++;
            end
            chk("032_bound", 32'(c_pkts[0]), 32'd0);
        end
        c_pkts[1] = cli_req[1] ? 1 : 0;
        run_quiet("032_tail");
        chk("032_enough", 32'(d_log.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++) if (i < d_log.size()) chk("032_alt", 32'(d_log[i]), 32'((i % 2 == 0) ? 1 : 0));

        // randomized traffic
        gap_max = 3;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++) c_pkts[k] = int'($urandom_range(2, 8));
            run_quiet("rand");
        end

`ifdef TX_ARB_TIMEOUT_EN
        // client 0 never acked: watchdog drops it, client 1 is served, client 0 stays masked
        do_reset();
        d_log.delete();
        mreq0_cnt = 0;
        cli_len[10:0] = 11'd20;
        cli_len[21:11] = 11'd30;
        cli_req[0] = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i == 2) cli_req[1] = 1'b1;
            cli_data = 16'($urandom);
            tick();
        end
        chk("034_mreq_cycles", 32'(mreq0_cnt), 32'd16);
        chk("034_timeout_err", 32'(timeout_err), 32'd1);
        cli_req[1] = 1'b0;
        repeat (10) tick();
        chk("034_log_len", 32'(d_log.size()), 32'd2);
        if (d_log.size() >= 2) chk("034_second", 32'(d_log[1]), 32'd1);
        cli_req[0] = 1'b0;
        tick();
        cli_req[0] = 1'b1;
        repeat (3) tick();
        chk("034_regrant", 32'(d_log.size()), 32'd3);
        cli_req[0] = 1'b0;
        repeat (4) tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
